// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: byte-source, transmitter and grant signals shared by the arbiter and its surroundings
interface uart_tx_arbiter_if;
  logic adcValid;
  logic [7:0] adcData;
  logic adcStrobe;
  logic genValid;
  logic [7:0] genData;
  logic genStrobe;
  logic txBusy;
  logic txStart;
  logic [7:0] txData;
  logic grantAdc;
  logic grantGen;
  modport master(
    input adcValid, adcData, genValid, genData, txBusy,
    output adcStrobe, genStrobe, txStart, txData, grantAdc, grantGen
  );
  modport slave(
    output adcValid, adcData, genValid, genData, txBusy,
    input adcStrobe, genStrobe, txStart, txData, grantAdc, grantGen
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, burst-limited sharing of one UART transmitter between ADC and general byte sources
module uart_tx_arbiter #(
  parameter logic [7:0] ADC_HDR = 8'hA5,
  parameter logic [7:0] GEN_HDR = 8'h5A,
  parameter int BURST = 16
) (
  input logic Clock,
  input logic Reset,
  uart_tx_arbiter_if.master bus
);
  localparam int CW = $clog2(BURST + 1);
  typedef enum logic [2:0] {IDLE, HDR, HDR_WAIT, DATA, DATA_WAIT} state_t;
  state_t state, stateNext;
  logic [CW-1:0] count, countNext;
  logic lastAdc, lastAdcNext, sawBusy, sawBusyNext;
  logic txStartNext, adcStrobeNext, genStrobeNext, grantAdcNext, grantGenNext;
  logic [7:0] txDataNext;
  logic srcValid;
  logic [7:0] srcData;
  assign srcValid = bus.grantAdc ? bus.adcValid : bus.genValid;
  assign srcData = bus.grantAdc ? bus.adcData : bus.genData;
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) begin
      state <= IDLE;
      count <= '0;
      lastAdc <= 1'b0;
      sawBusy <= 1'b0;
      bus.txStart <= 1'b0;
      bus.txData <= 8'h00;
      bus.adcStrobe <= 1'b0;
      bus.genStrobe <= 1'b0;
      bus.grantAdc <= 1'b0;
      bus.grantGen <= 1'b0;
    end else begin
      state <= stateNext;
      count <= countNext;
      lastAdc <= lastAdcNext;
      sawBusy <= sawBusyNext;
      bus.txStart <= txStartNext;
      bus.txData <= txDataNext;
      bus.adcStrobe <= adcStrobeNext;
      bus.genStrobe <= genStrobeNext;
      bus.grantAdc <= grantAdcNext;
      bus.grantGen <= grantGenNext;
    end
  always_comb begin
    stateNext = state;
    countNext = count;
    lastAdcNext = lastAdc;
    sawBusyNext = sawBusy;
    txStartNext = 1'b0;
    txDataNext = bus.txData;
    adcStrobeNext = 1'b0;
    genStrobeNext = 1'b0;
    grantAdcNext = bus.grantAdc;
    grantGenNext = bus.grantGen;
    case (state)
      IDLE:
        if (bus.adcValid || bus.genValid) begin
          // on a tie the source that did not own the last packet wins
          grantAdcNext = bus.adcValid && (!bus.genValid || !lastAdc);
          grantGenNext = !grantAdcNext;
          countNext = '0;
          stateNext = HDR;
        end
      HDR:
        if (!bus.txBusy) begin
          txStartNext = 1'b1;
          txDataNext = bus.grantAdc ? ADC_HDR : GEN_HDR;
          sawBusyNext = 1'b0;
          stateNext = HDR_WAIT;
        end
      HDR_WAIT, DATA_WAIT: begin
        sawBusyNext = sawBusy || bus.txBusy;
        stateNext = sawBusy && !bus.txBusy ? DATA : state;
      end
      DATA:
        if (!srcValid || count == CW'(BURST)) begin
          lastAdcNext = bus.grantAdc;
          grantAdcNext = 1'b0;
          grantGenNext = 1'b0;
          stateNext = IDLE;
        end else if (!bus.txBusy) begin
          txStartNext = 1'b1;
          txDataNext = srcData;
          adcStrobeNext = bus.grantAdc;
          genStrobeNext = bus.grantGen;
          countNext = count + CW'(1);
          sawBusyNext = 1'b0;
          stateNext = DATA_WAIT;
        end
      default: stateNext = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenarios against a BURST=16 arbiter (a) and a BURST=4 arbiter under constant contention (b)
module tb_uart_tx_arbiter;
  logic Clock = 1'b0;
  logic Reset;
  always #5 Clock = ~Clock;
  uart_tx_arbiter_if a();
  uart_tx_arbiter_if b();
  uart_tx_arbiter #(.BURST(16)) dutA(.Clock(Clock), .Reset(Reset), .bus(a));
  uart_tx_arbiter #(.BURST(4)) dutB(.Clock(Clock), .Reset(Reset), .bus(b));
  int asserts = 0;
  int fails = 0;
  int dlyA = 1, lenA = 3, tcA = 0, violA = 0, stbAdcA = 0, stbGenA = 0;
  int baseAdcA = 0, baseGenA = 0, nAdcA = 0, nGenA = 0;
  bit enAdcA = 0, enGenA = 0;
  logic [7:0] memAdcA[64];
  logic [7:0] memGenA[64];
  logic [5:0] iAdcA, iGenA;
  logic [7:0] logA[$];
  int tcB = 0, violB = 0, stbAdcB = 0, stbGenB = 0;
  bit enB = 0;
  logic [7:0] logB[$];
  assign iAdcA = 6'(stbAdcA - baseAdcA);
  assign iGenA = 6'(stbGenA - baseGenA);
  assign a.adcValid = enAdcA && (stbAdcA - baseAdcA < nAdcA);
  assign a.adcData = memAdcA[iAdcA];
  assign a.genValid = enGenA && (stbGenA - baseGenA < nGenA);
  assign a.genData = memGenA[iGenA];
  assign a.txBusy = tcA > dlyA;
  assign b.adcValid = enB;
  assign b.genValid = enB;
  assign b.adcData = 8'h10 + 8'(stbAdcB);
  assign b.genData = 8'h80 + 8'(stbGenB);
  assign b.txBusy = tcB > 1;
  // transmitter models: busy rises dly cycles after txStart and stays high len cycles
  always @(posedge Clock) begin
    if (a.txStart) begin
      logA.push_back(a.txData);
      if (tcA != 0) violA <= violA + 1;
      tcA <= 1;
    end else if (tcA != 0) tcA <= tcA >= dlyA + lenA ? 0 : tcA + 1;
    if (((a.adcStrobe || a.genStrobe) && !a.txStart) || (a.grantAdc && a.grantGen)
        || (a.adcStrobe && !a.grantAdc) || (a.genStrobe && !a.grantGen)) violA <= violA + 1;
    if (a.adcStrobe) stbAdcA <= stbAdcA + 1;
    if (a.genStrobe) stbGenA <= stbGenA + 1;
  end
  always @(posedge Clock) begin
    if (b.txStart) begin
      logB.push_back(b.txData);
      if (tcB != 0) violB <= violB + 1;
      tcB <= 1;
    end else if (tcB != 0) tcB <= tcB >= 4 ? 0 : tcB + 1;
    if (((b.adcStrobe || b.genStrobe) && !b.txStart) || (b.grantAdc && b.grantGen)) violB <= violB + 1;
    if (b.adcStrobe) stbAdcB <= stbAdcB + 1;
    if (b.genStrobe) stbGenB <= stbGenB + 1;
  end
  task automatic waitDoneA(input int maxc, output bit ok);
    int t = 0;
    do begin
      @(negedge Clock);
      t++;
    end while ((a.grantAdc || a.grantGen || a.adcValid || a.genValid || tcA != 0) && t < maxc);
    ok = t < maxc;
  endtask
  task automatic test_reset;
    Reset = 1'b1;
    @(negedge Clock);
    asserts++; if (a.txStart !== 1'b0) begin fails++; $display("FAIL reset_txStart: got %b expected 0", a.txStart); end
    asserts++; if (a.txData !== 8'h00) begin fails++; $display("FAIL reset_txData: got %h expected 00", a.txData); end
    asserts++; if (a.adcStrobe !== 1'b0 || a.genStrobe !== 1'b0) begin fails++; $display("FAIL reset_strobes: got %b%b expected 00", a.adcStrobe, a.genStrobe); end
    asserts++; if (a.grantAdc !== 1'b0 || a.grantGen !== 1'b0) begin fails++; $display("FAIL reset_grants: got %b%b expected 00", a.grantAdc, a.grantGen); end
    enB = 1'b1;
    @(negedge Clock);
    @(negedge Clock);
    asserts++; if (b.grantAdc !== 1'b0 || b.grantGen !== 1'b0 || b.txStart !== 1'b0) begin fails++; $display("FAIL reset_hold_b: grants=%b%b txStart=%b expected 000", b.grantAdc, b.grantGen, b.txStart); end
    Reset = 1'b0;
  endtask
  task automatic test_contention;
    int t = 0;
    logic [7:0] e[11] = '{8'hA5, 8'h10, 8'h11, 8'h12, 8'h13, 8'h5A, 8'h80, 8'h81, 8'h82, 8'h83, 8'hA5};
    while (logB.size() < 11 && t < 2000) begin
      @(negedge Clock);
      t++;
    end
    asserts++; if (t >= 2000) begin fails++; $display("FAIL contention_timeout: got %0d bytes expected 11", logB.size()); end
    for (int i = 0; i < 11; i++) begin
      asserts++; if (logB[i] !== e[i]) begin fails++; $display("FAIL contention_byte%0d: got %h expected %h", i, logB[i], e[i]); end
    end
    asserts++; if (violB != 0) begin fails++; $display("FAIL contention_protocol: got %0d violations expected 0", violB); end
  endtask
  task automatic test_gen_only;
    int s0 = logA.size(), g0 = stbGenA;
    bit ok;
    logic [7:0] e[4] = '{8'h5A, 8'h41, 8'h42, 8'h43};
    memGenA[0] = 8'h41; memGenA[1] = 8'h42; memGenA[2] = 8'h43;
    baseGenA = stbGenA; nGenA = 3; enGenA = 1'b1;
    @(negedge Clock);
    @(negedge Clock);
    asserts++; if (a.txStart !== 1'b1 || a.txData !== 8'h5A) begin fails++; $display("FAIL gen_hdr_latency: got start=%b data=%h expected 1/5a", a.txStart, a.txData); end
    waitDoneA(500, ok);
    asserts++; if (!ok) begin fails++; $display("FAIL gen_timeout: got grants=%b%b expected release", a.grantAdc, a.grantGen); end
    asserts++; if (logA.size() - s0 != 4) begin fails++; $display("FAIL gen_count: got %0d bytes expected 4", logA.size() - s0); end
    for (int i = 0; i < 4; i++) begin
      asserts++; if (logA[s0 + i] !== e[i]) begin fails++; $display("FAIL gen_byte%0d: got %h expected %h", i, logA[s0 + i], e[i]); end
    end
    asserts++; if (stbGenA - g0 != 3) begin fails++; $display("FAIL gen_strobes: got %0d expected 3", stbGenA - g0); end
    asserts++; if (violA != 0) begin fails++; $display("FAIL gen_protocol: got %0d violations expected 0", violA); end
    enGenA = 1'b0;
  endtask
  task automatic test_long_adc;
    int s0 = logA.size(), a0 = stbAdcA;
    bit ok;
    logic [7:0] e[22];
    for (int i = 0; i < 22; i++)
      e[i] = (i == 0 || i == 17) ? 8'hA5 : (i < 17 ? 8'hC0 + 8'(i - 1) : 8'hD0 + 8'(i - 18));
    for (int i = 0; i < 20; i++) memAdcA[i] = 8'hC0 + 8'(i);
    baseAdcA = stbAdcA; nAdcA = 20; enAdcA = 1'b1;
    waitDoneA(2000, ok);
    asserts++; if (!ok) begin fails++; $display("FAIL adc_timeout: got grants=%b%b expected release", a.grantAdc, a.grantGen); end
    asserts++; if (logA.size() - s0 != 22) begin fails++; $display("FAIL adc_count: got %0d bytes expected 22", logA.size() - s0); end
    for (int i = 0; i < 22; i++) begin
      asserts++; if (logA[s0 + i] !== e[i]) begin fails++; $display("FAIL adc_byte%0d: got %h expected %h", i, logA[s0 + i], e[i]); end
    end
    asserts++; if (stbAdcA - a0 != 20) begin fails++; $display("FAIL adc_strobes: got %0d expected 20", stbAdcA - a0); end
    enAdcA = 1'b0;
  endtask
  task automatic test_slow_busy;
    int s0 = logA.size(), t = 0, k = 0;
    bit ok;
    dlyA = 3; lenA = 100;
    memGenA[0] = 8'h61; memGenA[1] = 8'h62;
    baseGenA = stbGenA; nGenA = 2; enGenA = 1'b1;
    while (!a.txBusy && t < 50) begin @(negedge Clock); t++; end
    while (a.txBusy && t < 300) begin @(negedge Clock); t++; end
    while (!a.txStart && k < 10) begin @(negedge Clock); k++; end
    asserts++; if (k != 2 || a.txData !== 8'h61) begin fails++; $display("FAIL slow_latency: got %0d cycles data=%h expected 2/61", k, a.txData); end
    waitDoneA(1500, ok);
    asserts++; if (!ok) begin fails++; $display("FAIL slow_timeout: got grants=%b%b expected release", a.grantAdc, a.grantGen); end
    asserts++; if (logA.size() - s0 != 3 || logA[s0 + 2] !== 8'h62) begin fails++; $display("FAIL slow_starts: got %0d starts expected 3", logA.size() - s0); end
    asserts++; if (violA != 0) begin fails++; $display("FAIL slow_overlap: got %0d violations expected 0", violA); end
    enGenA = 1'b0;
    dlyA = 1; lenA = 3;
  endtask
  task automatic test_valid_drop;
    int s0 = logA.size(), a0 = stbAdcA, s1;
    bit ok;
    logic [7:0] e[4] = '{8'h5A, 8'h44, 8'hA5, 8'h33};
    memAdcA[0] = 8'h77;
    baseAdcA = stbAdcA; nAdcA = 1; enAdcA = 1'b1;
    @(negedge Clock);
    enAdcA = 1'b0;
    waitDoneA(200, ok);
    asserts++; if (!ok || logA.size() - s0 != 1 || logA[s0] !== 8'hA5) begin fails++; $display("FAIL drop_header_only: got %0d bytes first=%h expected 1/a5", logA.size() - s0, logA[s0]); end
    asserts++; if (stbAdcA - a0 != 0) begin fails++; $display("FAIL drop_strobes: got %0d expected 0", stbAdcA - a0); end
    s1 = logA.size();
    memAdcA[0] = 8'h33; memGenA[0] = 8'h44;
    baseAdcA = stbAdcA; nAdcA = 1; enAdcA = 1'b1;
    baseGenA = stbGenA; nGenA = 1; enGenA = 1'b1;
    @(negedge Clock);
    @(negedge Clock);
    asserts++; if (a.txStart !== 1'b1 || a.grantGen !== 1'b1 || a.txData !== 8'h5A) begin fails++; $display("FAIL drop_lastgrant: got start=%b grantGen=%b data=%h expected 1/1/5a", a.txStart, a.grantGen, a.txData); end
    waitDoneA(500, ok);
    asserts++; if (!ok || logA.size() - s1 != 4) begin fails++; $display("FAIL drop_followup_count: got %0d bytes expected 4", logA.size() - s1); end
    for (int i = 0; i < 4; i++) begin
      asserts++; if (logA[s1 + i] !== e[i]) begin fails++; $display("FAIL drop_followup_byte%0d: got %h expected %h", i, logA[s1 + i], e[i]); end
    end
    enAdcA = 1'b0; enGenA = 1'b0;
  endtask
  task automatic test_reset_mid;
    int s0 = logA.size(), g0 = stbGenA, t = 0;
    bit ok;
    logic [7:0] e[5] = '{8'h5A, 8'h91, 8'h5A, 8'h92, 8'h93};
    lenA = 20;
    memGenA[0] = 8'h91; memGenA[1] = 8'h92; memGenA[2] = 8'h93;
    baseGenA = stbGenA; nGenA = 3; enGenA = 1'b1;
    while (stbGenA == g0 && t < 300) begin @(negedge Clock); t++; end
    while (!a.txBusy && t < 300) begin @(negedge Clock); t++; end
    asserts++; if (t >= 300 || a.grantGen !== 1'b1) begin fails++; $display("FAIL rst_mid_setup: got grantGen=%b busy=%b expected 1/1", a.grantGen, a.txBusy); end
    Reset = 1'b1;
    #1;
    asserts++; if (a.grantAdc !== 1'b0 || a.grantGen !== 1'b0) begin fails++; $display("FAIL rst_mid_grants: got %b%b expected 00", a.grantAdc, a.grantGen); end
    asserts++; if (a.txStart !== 1'b0 || a.txData !== 8'h00 || a.genStrobe !== 1'b0 || a.adcStrobe !== 1'b0) begin fails++; $display("FAIL rst_mid_outputs: got start=%b data=%h strobes=%b%b expected 0/00/00", a.txStart, a.txData, a.adcStrobe, a.genStrobe); end
    @(negedge Clock);
    Reset = 1'b0;
    waitDoneA(800, ok);
    asserts++; if (!ok || logA.size() - s0 != 5) begin fails++; $display("FAIL rst_mid_count: got %0d bytes expected 5", logA.size() - s0); end
    for (int i = 0; i < 5; i++) begin
      asserts++; if (logA[s0 + i] !== e[i]) begin fails++; $display("FAIL rst_mid_byte%0d: got %h expected %h", i, logA[s0 + i], e[i]); end
    end
    asserts++; if (stbGenA - g0 != 3) begin fails++; $display("FAIL rst_mid_strobes: got %0d expected 3", stbGenA - g0); end
    enGenA = 1'b0;
    lenA = 3;
  endtask
  initial begin
    test_reset;
    test_contention;
    test_gen_only;
    test_long_adc;
    test_slow_busy;
    test_valid_drop;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter (async_transmitter) between two byte sources: the ADC sample stream and the general-message path.
- Grants the transmitter to one source per packet and prefixes each packet with a source-identifying header byte.
- Limits each grant to a bounded burst and alternates round-robin at packet boundaries, so ADC streaming cannot starve general messages.
- Sits between the ADC FIFO / general UART FIFO outputs and the transmitter's TxD_start / TxD_data / TxD_busy pins.

Parameters:
- ADC_HDR, 8'hA5, header byte sent before each ADC packet.
- GEN_HDR, 8'h5A, header byte sent before each general packet.
- BURST, 16, maximum data bytes per grant (1..255); the header is not counted.

Ports:
- Clock  input  1  system clock
- Reset  input  1  reset (see Interface below)
- adcValid  input  1  ADC source has a byte on adcData
- adcData  input  8  ADC byte
- adcStrobe  output  1  one-cycle pulse: adcData consumed this cycle
- genValid  input  1  general source has a byte on genData
- genData  input  8  general byte
- genStrobe  output  1  one-cycle pulse: genData consumed this cycle
- txBusy  input  1  TxD_busy from transmitter
- txStart  output  1  one-cycle pulse to TxD_start
- txData  output  8  byte to TxD_data, registered
- grantAdc  output  1  ADC currently owns transmitter
- grantGen  output  1  general source currently owns transmitter

Behaviour:
Interface:
- One clock, Clock; reset is asynchronous and active-high, Reset.
- All outputs are registered.
- Reset values: txStart=0, txData=8'h00, adcStrobe=0, genStrobe=0, grantAdc=0, grantGen=0.
- Internal reset values: state=IDLE, count=0, lastGrant=GEN (so ADC wins the first tie), sawBusy=0.

State machine: IDLE, HDR, HDR_WAIT, DATA, DATA_WAIT.
- IDLE:
  - If exactly one of adcValid/genValid is high, grant that source.
  - If both are high, grant the source opposite lastGrant.
  - On a grant: set grantX=1, count=0, go to HDR.
  - Otherwise stay in IDLE.
- HDR:
  - When txBusy=0: pulse txStart with txData = ADC_HDR or GEN_HDR, clear sawBusy, go to HDR_WAIT.
  - While txBusy=1: hold.
- HDR_WAIT / DATA_WAIT:
  - Set sawBusy when txBusy=1.
  - Leave when sawBusy=1 and txBusy=0: HDR_WAIT goes to DATA, DATA_WAIT goes to DATA.
  - A byte completes only after an observed busy high-then-low; a busy that never rises holds the FSM there. No timeout.
- DATA, evaluated in priority order:
  - Granted source's valid=0, or count==BURST: release the grant (grantX=0), set lastGrant to the released source, go to IDLE. No byte is sent.
  - Else, when txBusy=0: in the same cycle pulse txStart, set txData to the source byte, and pulse that source's strobe. Then count=count+1, clear sawBusy, go to DATA_WAIT.
  - The strobe must be a single cycle, coincident with txStart.
- A valid drop between HDR and the first DATA byte yields a header-only packet; this is legal.
- Requests from the non-granted source are ignored until IDLE.
- count width: clog2(BURST+1) bits; it never wraps.
- Latency:
  - Request in IDLE to header txStart: 2 cycles, given txBusy=0.
  - Byte completion (txBusy fall) to next data txStart: 2 cycles.
- Data is sampled only on the strobe cycle; the source must hold it stable while valid.
- Reset mid-operation: all outputs clear asynchronously. A byte already in the transmitter finishes on its own. After reset the FSM starts in IDLE and ignores the current txBusy state, except that HDR still waits for txBusy=0.
- grantAdc and grantGen are never both high.
- txStart is never high on two consecutive cycles.

Test Plan:
- General message only: genValid high for 3 bytes 8'h41, 8'h42, 8'h43, then low. Required TxD byte sequence: 5A 41 42 43. genStrobe pulses exactly 3 times, each coincident with txStart. grantGen falls after the 3rd byte completes.
- Contention: adcValid and genValid both held high from reset with BURST=4. Required sequence: A5 + 4 ADC bytes, 5A + 4 gen bytes, then A5 again. Grants alternate and never overlap.
- Long ADC stream, 20 bytes, BURST=16, genValid low: ADC packets of 16 data bytes then 4 data bytes, each with an A5 header. adcStrobe count = 20.
- Slow busy: transmitter model holds txBusy for 100 cycles per byte, with a 3-cycle delay from txStart to the rise. No second txStart may occur before txBusy falls. Exactly one txStart per byte.
- Valid drops right after the header: adcValid pulses for 1 cycle in IDLE. Required output: header A5 only, zero adcStrobe, return to IDLE, lastGrant=ADC.
- Reset in DATA_WAIT, mid-packet: all outputs are 0 on the cycle Reset rises. After release with genValid high, the next packet starts with 5A and count restarts at 0.
